// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmitter and the UART Rx environment.
//   Contents:
//     uart_tx_state_e  - transmitter frame state (IDLE/START/DATA/PARITY/STOP)
//     PAR_EVEN/PAR_ODD - encodings of the PAR_TYP input
//     PRESCALE_8/16/32 - nominal clk-cycles-per-bit settings
//     eff_bit_last     - helper: last bit-timer count for a given prescale
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Terminal count of the bit timer for a requested prescale. A prescale of 0
  // is treated as 1 cycle per bit, so the terminal count is 0 in both cases.
  function automatic logic [31:0] eff_bit_last(input logic [31:0] prescale);
    if (prescale == 32'd0) begin
      return 32'd0;
    end
    return prescale - 32'd1;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_timer
//   Bit-period counter for the UART transmitter. Counts 0..P-1 while enabled,
//   where P is the prescale captured on i_load (0 is treated as 1). Raises
//   o_bit_done in the cycle the count sits at P-1, then wraps to 0.
// Ports:
//   clk        in   clock, all logic on posedge
//   RST        in   synchronous active-high reset
//   i_load     in   capture i_prescale and restart the count at 0
//   i_prescale in   clk cycles per bit
//   i_enable   in   count while high; held at 0 while low
//   o_bit_done out  high during the last cycle of every bit period
// -----------------------------------------------------------------------------
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_enable,
  output logic                  o_bit_done
);

  logic [PRESCALE_W-1:0] r_count;
  logic [PRESCALE_W-1:0] r_last;
  logic [PRESCALE_W-1:0] w_load_last;
  logic [31:0]           w_load_last_full;
  logic                  w_wrap;

  // Terminal count is stored rather than P itself so the compare is a plain
  // equality and the prescale==0 case needs no special handling later.
  assign w_load_last_full = eff_bit_last(32'(i_prescale));
  assign w_load_last      = w_load_last_full[PRESCALE_W-1:0];

  assign w_wrap     = (r_count == r_last);
  assign o_bit_done = i_enable && w_wrap;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_count <= '0;
      r_last  <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_last  <= w_load_last;
    end else if (i_enable) begin
      if (w_wrap) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else begin
      r_count <= '0;
    end
  end

endmodule : uart_tx_bit_timer

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Serial UART transmitter. Accepts a parallel word with a one-cycle
//   DATA_Valid strobe while idle and sends a frame on TX_OUT:
//   start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
//   stop bit (1). Every bit lasts P clk cycles (P = latched prescale, 0 -> 1).
// Ports:
//   clk        in   clock, all logic on posedge
//   RST        in   synchronous active-high reset; aborts any frame in flight
//   P_DATA     in   word to send, sampled on acceptance
//   DATA_Valid in   request strobe, accepted only while idle
//   PAR_EN     in   1 = append parity bit, sampled on acceptance
//   PAR_TYP    in   0 = even, 1 = odd parity, sampled on acceptance
//   prescale   in   clk cycles per bit, sampled on acceptance
//   TX_OUT     out  serial line, idles high (registered)
//   BUSY       out  high while a frame is in flight (registered)
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_tx_state_e        r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_bit_idx;
  logic                  r_parity;
  logic                  r_par_en;
  logic                  r_tx_out;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_bit_done;
  logic [DATA_WIDTH-1:0] w_shift_next;

  // A request is only taken in IDLE; on the edge that ends the stop bit the
  // state is still STOP, so a strobe there is dropped and the line gets at
  // least one idle cycle between frames.
  assign w_accept     = (r_state == IDLE) && DATA_Valid;
  assign w_shift_next = r_shift >> 1;

  uart_tx_bit_timer #(
    .PRESCALE_W (PRESCALE_W)
  ) u_bit_timer (
    .clk        (clk),
    .RST        (RST),
    .i_load     (w_accept),
    .i_prescale (prescale),
    .i_enable   (r_busy),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b0;
      r_par_en  <= 1'b0;
      r_tx_out  <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx_out <= 1'b1;
          if (w_accept) begin
            r_state   <= START;
            r_shift   <= P_DATA;
            r_bit_idx <= '0;
            r_parity  <= (^P_DATA) ^ PAR_TYP;
            r_par_en  <= PAR_EN;
            r_tx_out  <= 1'b0;
            r_busy    <= 1'b1;
          end
        end

        START: begin
          if (w_bit_done) begin
            r_state  <= DATA;
            r_tx_out <= r_shift[0];
          end
        end

        // The current data bit always sits in r_shift[0]; the next one is
        // taken from the pre-shifted value so TX_OUT stays registered.
        DATA: begin
          if (w_bit_done) begin
            if (r_bit_idx == LAST_IDX) begin
              if (r_par_en) begin
                r_state  <= PARITY;
                r_tx_out <= r_parity;
              end else begin
                r_state  <= STOP;
                r_tx_out <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= w_shift_next;
              r_tx_out  <= w_shift_next[0];
            end
          end
        end

        PARITY: begin
          if (w_bit_done) begin
            r_state  <= STOP;
            r_tx_out <= 1'b1;
          end
        end

        STOP: begin
          if (w_bit_done) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
            r_tx_out  <= 1'b1;
            r_busy    <= 1'b0;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = r_tx_out;
  assign BUSY   = r_busy;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int n_checks;
  int n_errors;

  uart_tx #(
    .DATA_WIDTH (8),
    .PRESCALE_W (6)
  ) dut (
    .clk        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .DATA_Valid (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .prescale   (prescale),
    .TX_OUT     (tx_out),
    .BUSY       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Idle cycles with no request: line high, not busy.
  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_tx"}, 32'(tx_out), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
    end
  endtask

  // Reference frame: expected line level for each bit of the frame.
  task automatic build_frame(input logic [7:0] d, input bit pe, input bit pt, ref int bits[$]);
    bits.delete();
    bits.push_back(0);
    for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
    if (pe) begin
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      // even parity makes the total count of ones even, odd makes it odd
      bits.push_back(pt ? ((ones % 2 == 0) ? 1 : 0) : ones % 2);
    end
    bits.push_back(1);
  endtask

  // Send one frame and compare every cycle against the reference.
  // junk_k >= 0: pulse DATA_Valid with 8'hFF mid-frame at that cycle index.
  // stop_pulse: also pulse DATA_Valid on the edge that ends the stop bit.
  task automatic run_frame(input logic [7:0] d, input bit pe, input bit pt,
                           input logic [5:0] ps, input int junk_k, input bit stop_pulse);
    int bits[$];
    int p;
    int n;
    int busy_cnt;
    build_frame(d, pe, pt, bits);
    p = (ps == 6'd0) ? 1 : int'(ps);
    n = bits.size() * p;
    busy_cnt = 0;

    @(negedge clk);
    p_data = d; par_en = pe; par_typ = pt; prescale = ps; data_valid = 1'b1;

    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("frame_tx", 32'(tx_out), 32'(bits[k / p]));
      if (busy) busy_cnt++;
      data_valid = (k == junk_k) || (stop_pulse && (k == n - 1));
      // inputs change freely after acceptance; the frame must not notice
      p_data   = data_valid ? 8'hFF : 8'($urandom);
      par_en   = 1'($urandom);
      par_typ  = 1'($urandom);
      prescale = 6'($urandom);
    end

    @(negedge clk);
    check("end_tx", 32'(tx_out), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("busy_cycles", 32'(busy_cnt), 32'(n));
    data_valid = 1'b0;
    if (stop_pulse) idle_cycles(2, "stop_edge_ignored");
    $display("frame data=%02h par_en=%0d par_typ=%0d prescale=%0d busy_cycles=%0d",
             d, pe, pt, ps, busy_cnt);
  endtask

  // Abort a frame with reset during data bit 4, then send a clean frame.
  task automatic reset_mid_frame();
    int bits[$];
    int p;
    int stop_k;
    build_frame(8'hF0, 1'b0, 1'b0, bits);
    p = 8;
    stop_k = 5 * p + 3;  // inside data bit 4 (bit 0 of the frame is start)

    @(negedge clk);
    p_data = 8'hF0; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8; data_valid = 1'b1;
    for (int k = 0; k <= stop_k; k++) begin
      @(negedge clk);
      data_valid = 1'b0;
      check("abort_tx", 32'(tx_out), 32'(bits[k / p]));
      check("abort_busy", 32'(busy), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_tx", 32'(tx_out), 32'd1);
    check("abort_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle_cycles(3, "after_abort");
    $display("abort frame data=f0 at data bit 4");
    run_frame(8'h55, 1'b1, 1'b0, 6'd8, -1, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd8;

    // reset state
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_tx", 32'(tx_out), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    idle_cycles(20, "idle");
    $display("reset and idle done");

    // directed frames
    run_frame(8'hA5, 1'b1, 1'b0, 6'd8, -1, 1'b0);
    run_frame(8'h01, 1'b1, 1'b1, 6'd16, -1, 1'b0);
    run_frame(8'h01, 1'b0, 1'b1, 6'd16, -1, 1'b0);
    run_frame(8'h3C, 1'b1, 1'b0, 6'd16, 20, 1'b1);
    reset_mid_frame();

    // prescale boundaries
    run_frame(8'hC3, 1'b1, 1'b1, 6'd0, 4, 1'b1);
    run_frame(8'h7E, 1'b1, 1'b0, 6'd1, -1, 1'b1);
    run_frame(8'h96, 1'b0, 1'b0, 6'd2, 7, 1'b0);
    run_frame(8'h81, 1'b1, 1'b1, 6'd63, 100, 1'b0);

    // random frames at nominal rates
    for (int f = 0; f < 200; f++) begin
      logic [7:0] d;
      logic [5:0] ps;
      int sel;
      int n;
      bit pe;
      d   = 8'($urandom);
      pe  = 1'($urandom);
      sel = int'($urandom_range(2, 0));
      ps  = (sel == 0) ? 6'd8 : ((sel == 1) ? 6'd16 : 6'd32);
      n   = (10 + int'(pe)) * int'(ps);
      run_frame(d, pe, 1'($urandom),
                ps, ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 2, 1)) : -1,
                1'($urandom));
      idle_cycles(int'($urandom_range(2, 0)), "gap");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_tx
